// File: rtl/bam_prod_accumulator.sv
// Packet accumulator for broken-array multiplier products. Only product bits
// above the always-zero cut are summed; the result is handed off over valid/ready.
module bam_prod_accumulator #(
  parameter int ACC_W = 24,
  parameter int DROP  = 12,
  parameter int CNT_W = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             drop_nz,
  output logic             sum_valid,
  input  logic             sum_ready
);

  localparam int AW = ACC_W - DROP;
  localparam int PW = 16 - DROP;

  // Handshakes: an input beat transfers on a rising edge where prod_valid and
  // prod_ready are both high; a result transfers where sum_valid and sum_ready
  // are both high. Both ready/valid outputs are registered copies of the state.
  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             prod_ready_d, sum_valid_d;
  logic             beat, done;
  logic [AW-1:0]    acc_q, acc_upd;
  logic [AW:0]      acc_ext;
  logic [CNT_W-1:0] cnt_q, cnt_upd;
  logic             ovf_q, ovf_upd, dnz_q, dnz_upd, carry;

  assign beat = prod_valid && prod_ready;
  assign done = (state_q == ST_HOLD) && sum_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (beat && prod_last) state_d = ST_HOLD;
      ST_HOLD: if (sum_ready)         state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // Output logic: next values of the registered handshake outputs
  always_comb begin
    prod_ready_d = (state_d == ST_ACC);
    sum_valid_d  = (state_d == ST_HOLD);
  end

  // prod_ready resets low, so the first beat lands one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_ready <= 1'b0;
      sum_valid  <= 1'b0;
    end else begin
      prod_ready <= prod_ready_d;
      sum_valid  <= sum_valid_d;
    end
  end

  // Datapath: one extra bit catches the carry-out of the truncated sum.
  always_comb begin
    acc_ext = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, prod[15:DROP]};
    carry   = acc_ext[AW];
    acc_upd = (SAT && carry) ? {AW{1'b1}} : acc_ext[AW-1:0];
    cnt_upd = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    ovf_upd = ovf_q | carry;
    dnz_upd = dnz_q | (|prod[DROP-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      dnz_q <= 1'b0;
    end else if (done) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      dnz_q <= 1'b0;
    end else if (beat) begin
      acc_q <= acc_upd;
      cnt_q <= cnt_upd;
      ovf_q <= ovf_upd;
      dnz_q <= dnz_upd;
    end
  end

  // Result registers: loaded with the final beat folded in, held through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      drop_nz <= 1'b0;
    end else if (done) begin
      sum     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      drop_nz <= 1'b0;
    end else if (beat && prod_last) begin
      sum     <= {acc_upd, {DROP{1'b0}}};
      cnt     <= cnt_upd;
      ovf     <= ovf_upd;
      drop_nz <= dnz_upd;
    end
  end

endmodule

// File: tb/tb_bam_prod_accumulator.sv
// Bench for bam_prod_accumulator: a saturating and a wrapping instance share one
// input stream; a reference model feeds per-instance expected queues.
module tb_bam_prod_accumulator;

  localparam int ACC_W = 24;
  localparam int DROP  = 12;
  localparam int CNT_W = 16;
  localparam int RW    = ACC_W + CNT_W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] prod = '0;
  logic prod_valid = 1'b0;
  logic prod_last = 1'b0;
  logic sum_ready = 1'b1;

  logic pr_s, ovf_s, dnz_s, sv_s;
  logic pr_w, ovf_w, dnz_w, sv_w;
  logic [ACC_W-1:0] sum_s, sum_w;
  logic [CNT_W-1:0] cnt_s, cnt_w;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [RW-1:0] exp_q_s[$];
  logic [RW-1:0] exp_q_w[$];

  int unsigned m_acc[2];
  int unsigned m_cnt[2];
  bit m_ovf[2];
  bit m_dnz[2];

  bam_prod_accumulator #(.ACC_W(ACC_W), .DROP(DROP), .CNT_W(CNT_W), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(pr_s), .sum(sum_s), .cnt(cnt_s), .ovf(ovf_s), .drop_nz(dnz_s),
    .sum_valid(sv_s), .sum_ready(sum_ready)
  );

  bam_prod_accumulator #(.ACC_W(ACC_W), .DROP(DROP), .CNT_W(CNT_W), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(pr_w), .sum(sum_w), .cnt(cnt_w), .ovf(ovf_w), .drop_nz(dnz_w),
    .sum_valid(sv_w), .sum_ready(sum_ready)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
      m_dnz[k] = 1'b0;
    end
  endtask

  // Reference model; index 0 saturates, index 1 wraps.
  task automatic model_beat(input logic [15:0] p, input bit last);
    int unsigned t;
    logic [RW-1:0] e;
    for (int k = 0; k < 2; k++) begin
      t = m_acc[k] + int'(p[15:12]);
      if (t > 4095) begin
        m_ovf[k] = 1'b1;
        m_acc[k] = (k == 0) ? 4095 : t - 4096;
      end else begin
        m_acc[k] = t;
      end
      if (m_cnt[k] < 65535) m_cnt[k]++;
      if (p[11:0] != 12'h0) m_dnz[k] = 1'b1;
    end
    if (last) begin
      e = {m_acc[0][11:0], 12'h000, m_cnt[0][15:0], m_ovf[0], m_dnz[0]};
      exp_q_s.push_back(e);
      e = {m_acc[1][11:0], 12'h000, m_cnt[1][15:0], m_ovf[1], m_dnz[1]};
      exp_q_w.push_back(e);
      model_clear();
    end
  endtask

  // Driver: called at posedge+1; returns at posedge+1 after the beat transfers.
  task automatic send_beat(input logic [15:0] p, input bit last);
    bit took = 1'b0;
    prod = p;
    prod_valid = 1'b1;
    prod_last = last;
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      took = pr_s;
      @(posedge clk);
      #1;
    end
    prod_valid = 1'b0;
    prod_last = 1'b0;
    if (took) begin
      model_beat(p, last);
    end else begin
      chk_cnt++;
      $display("FAIL beat_accept_timeout: prod_ready stayed 0 for 100 cycles, required 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: compares each result on the cycle it is consumed.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (rst_n && sum_ready) begin
      if (sv_s) begin
        if (exp_q_s.size() == 0) begin
          chk_cnt++;
          $display("FAIL sat_unexpected: result 0x%0h presented, no result expected", sum_s);
        end else begin
          e = exp_q_s.pop_front();
          check("sat_result", 64'({sum_s, cnt_s, ovf_s, dnz_s}), 64'(e));
        end
      end
      if (sv_w) begin
        if (exp_q_w.size() == 0) begin
          chk_cnt++;
          $display("FAIL wrap_unexpected: result 0x%0h presented, no result expected", sum_w);
        end else begin
          e = exp_q_w.pop_front();
          check("wrap_result", 64'({sum_w, cnt_w, ovf_w, dnz_w}), 64'(e));
        end
      end
    end
  end

  initial begin
    int sv_n, pr_low, len, gap;
    logic [19:0] big;
    model_clear();

    // Reset state
    #12;
    check("rst_sum", 64'(sum_s), 64'h0);
    check("rst_cnt", 64'(cnt_s), 64'h0);
    check("rst_valid", 64'({sv_s, sv_w}), 64'h0);
    check("rst_ready", 64'({pr_s, pr_w}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_after_release", 64'({pr_s, pr_w}), 64'h3);
    @(posedge clk);
    #1;

    // Three-beat packet, one-cycle valid pulse
    send_beat(16'h1000, 1'b0);
    send_beat(16'h1000, 1'b0);
    send_beat(16'h1000, 1'b1);
    @(negedge clk);
    check("t1_sum", 64'(sum_s), 64'h003000);
    check("t1_cnt", 64'(cnt_s), 64'd3);
    check("t1_ovf", 64'(ovf_s), 64'h0);
    sv_n = int'(sv_s);
    pr_low = int'(!pr_s);
    repeat (4) begin
      @(negedge clk);
      sv_n += int'(sv_s);
      pr_low += int'(!pr_s);
    end
    check("t1_valid_cycles", 64'(sv_n), 64'd1);
    check("t1_ready_low_cycles", 64'(pr_low), 64'd1);
    @(posedge clk);
    #1;

    // Truncated input and ignored low bits
    big = 20'hE1000;
    send_beat(big[15:0], 1'b1);
    @(negedge clk);
    check("t2a_sum", 64'(sum_s), 64'h001000);
    check("t2a_cnt", 64'(cnt_s), 64'd1);
    check("t2a_dnz", 64'(dnz_s), 64'h0);
    @(posedge clk);
    #1;
    send_beat(16'h1234, 1'b1);
    @(negedge clk);
    check("t2b_sum", 64'(sum_s), 64'h001000);
    check("t2b_dnz", 64'(dnz_s), 64'h1);
    @(posedge clk);
    #1;

    // Overflow: saturating vs wrapping
    for (int i = 0; i < 274; i++) send_beat(16'hF000, i == 273);
    @(negedge clk);
    check("t3_sat_sum", 64'(sum_s), 64'hFFF000);
    check("t3_sat_ovf", 64'(ovf_s), 64'h1);
    check("t3_sat_cnt", 64'(cnt_s), 64'd274);
    check("t3_wrap_sum", 64'(sum_w), 64'h00E000);
    check("t3_wrap_ovf", 64'(ovf_w), 64'h1);
    check("t3_wrap_cnt", 64'(cnt_w), 64'd274);
    @(posedge clk);
    #1;

    // Backpressure: result held, beats ignored
    sum_ready = 1'b0;
    send_beat(16'h5000, 1'b0);
    send_beat(16'h2000, 1'b1);
    prod = 16'hFFFF;
    prod_valid = 1'b1;
    prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_ready_low", 64'(pr_s), 64'h0);
      check("t4_valid_high", 64'(sv_s), 64'h1);
      check("t4_sum_stable", 64'(sum_s), 64'h007000);
      check("t4_cnt_stable", 64'(cnt_s), 64'd2);
      @(posedge clk);
      #1;
    end
    prod_valid = 1'b0;
    prod_last = 1'b0;
    sum_ready = 1'b1;
    idle(1);
    send_beat(16'h3000, 1'b1);
    @(negedge clk);
    check("t4_next_sum", 64'(sum_s), 64'h003000);
    check("t4_next_cnt", 64'(cnt_s), 64'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-packet
    send_beat(16'h4000, 1'b0);
    send_beat(16'h4000, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_sum", 64'({sum_s, sum_w}), 64'h0);
    check("t5_rst_cnt", 64'({cnt_s, cnt_w}), 64'h0);
    check("t5_rst_flags", 64'({ovf_s, dnz_s, sv_s, pr_s, ovf_w, dnz_w, sv_w, pr_w}), 64'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(16'h2000, 1'b1);
    @(negedge clk);
    check("t5_next_sum", 64'(sum_s), 64'h002000);
    check("t5_next_cnt", 64'(cnt_s), 64'd1);
    @(posedge clk);
    #1;

    // Random packets with random gaps
    for (int pk = 0; pk < 1000; pk++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        gap = $urandom_range(0, 2);
        idle(gap);
        send_beat(16'($urandom_range(0, 65535)), b == len - 1);
      end
    end

    for (int i = 0; i < 20 && (exp_q_s.size() + exp_q_w.size()) != 0; i++) idle(1);
    check("queues_drained", 64'(exp_q_s.size() + exp_q_w.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
